trace_buffer_ctrl: RTL and testbench

Capture/readout controller that sits directly in front of the tracer's dual-port block RAM (`RAM2P_BRAM`) and drives both of its ports. It writes timestamped kernel trace words into the RAM through port 0 as a ring, addressed in arrival order. On request it drains the stored words oldest-first through port 1 onto a valid/ready stream toward the host-side packer.

---
 rtl/trace_buffer_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_trace_buffer_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// trace_buffer_ctrl
//
// Capture/readout controller in front of a dual-port block RAM. Trace words
// are written through RAM port 0 in arrival order as a ring. On a dump
// request the stored words are read oldest-first through RAM port 1 and
// presented on a valid/ready stream through a 2-entry output buffer.
//
// Build option:
//   TRACE_WRAP_EN  defined   : ring mode, a full buffer overwrites the oldest
//                              word and the dump starts at the write pointer.
//                  undefined : stop-when-full, events on a full buffer are
//                              dropped and the dump always starts at 0.
//   In both modes 'overrun' is a sticky flag set by the first lost word.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   arm, stop, dump   control pulses (clear+capture / end capture / readout)
//   ev_valid, ev_data incoming trace words, no backpressure
//   ram_*0            RAM port 0 (write side), registered strobes
//   ram_*1, ram_q1    RAM port 1 (read side), read data one cycle after ce
//   out_valid/ready   readout stream handshake, out_data is the buffer head
//   busy              high in CAPTURE or DUMP
//   count             words stored, 0..2**AddrWidth
//   overrun           sticky lost-word flag
// -----------------------------------------------------------------------------
module trace_buffer_ctrl #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 stop,
    input  logic                 dump,
    input  logic                 ev_valid,
    input  logic [DataWidth-1:0] ev_data,
    output logic [AddrWidth-1:0] ram_addr0,
    output logic [DataWidth-1:0] ram_data0,
    output logic                 ram_ce0,
    output logic                 ram_we0,
    output logic [AddrWidth-1:0] ram_addr1,
    output logic                 ram_ce1,
    output logic                 ram_we1,
    input  logic [DataWidth-1:0] ram_q1,
    output logic                 out_valid,
    output logic [DataWidth-1:0] out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [AddrWidth:0]   count,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DUMP    = 2'd2
    } state_t;

    localparam logic [AddrWidth:0] Depth = {1'b1, {AddrWidth{1'b0}}};

    state_t               state;
    state_t               next_state;

    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth:0]   remaining;
    logic                 in_flight;

    logic [DataWidth-1:0] obuf [2];
    logic                 obuf_wr;
    logic                 obuf_rd;
    logic [1:0]           obuf_occ;

    logic                 full;
    logic                 pop;
    logic [1:0]           pending;
    logic                 issue;
    logic                 start_arm;
    logic                 start_dump;
    logic                 ev_take;
    logic                 accept;
    logic                 lost;
    logic                 dump_done;

    assign full      = (count == Depth);
    assign out_valid = (obuf_occ != 2'd0);
    assign out_data  = out_valid ? obuf[obuf_rd] : '0;
    assign pop       = out_valid && out_ready;

    // Readout finishes when nothing is left to issue, nothing is in flight
    // and the buffer empties on this cycle's handshake.
    assign dump_done = (remaining == '0) && !in_flight &&
                       ((obuf_occ == 2'd0) || ((obuf_occ == 2'd1) && pop));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state
        // unassigned and infers a latch.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (arm) begin
                    next_state = CAPTURE;
                end else if (dump) begin
                    next_state = DUMP;
                end
            end
            CAPTURE: begin
                if (arm) begin
                    next_state = CAPTURE;
                end else if (stop) begin
                    next_state = IDLE;
                end
            end
            DUMP: begin
                if (dump_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / control decode
    // -------------------------------------------------------------------------
    always_comb begin
        busy       = (state != IDLE);
        start_arm  = arm && (state != DUMP);
        start_dump = dump && !arm && (state == IDLE);
        // An arm in CAPTURE restarts the buffer; a coincident event is not kept.
        ev_take    = (state == CAPTURE) && ev_valid && !arm;

        // Occupancy counts the slot freed by this cycle's handshake so a
        // steady ready stream sustains one word per cycle.
        pending    = obuf_occ - {1'b0, pop} + {1'b0, in_flight};
        issue      = (state == DUMP) && (remaining != '0) && (pending < 2'd2);

        ram_ce1    = issue;
        ram_addr1  = rd_ptr;
        ram_we1    = 1'b0;

`ifdef TRACE_WRAP_EN
        accept     = ev_take;
        lost       = ev_take && full;
`else
        accept     = ev_take && !full;
        lost       = ev_take && full;
`endif
    end

    // -------------------------------------------------------------------------
    // Capture and readout datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            remaining <= '0;
            in_flight <= 1'b0;
            obuf_wr   <= 1'b0;
            obuf_rd   <= 1'b0;
            obuf_occ  <= 2'd0;
            ram_ce0   <= 1'b0;
            ram_we0   <= 1'b0;
            ram_addr0 <= '0;
            ram_data0 <= '0;
        end else begin
            // Write strobes are registered: high in the cycle after the event.
            ram_ce0 <= accept;
            ram_we0 <= accept;
            if (accept) begin
                ram_addr0 <= wr_ptr;
                ram_data0 <= ev_data;
                wr_ptr    <= wr_ptr + 1'b1;
                if (!full) begin
                    count <= count + 1'b1;
                end
            end
            if (lost) begin
                overrun <= 1'b1;
            end
            if (start_arm) begin
                wr_ptr  <= '0;
                count   <= '0;
                overrun <= 1'b0;
            end

            if (start_dump) begin
`ifdef TRACE_WRAP_EN
                // A full ring that has wrapped holds its oldest word at wr_ptr.
                rd_ptr <= full ? wr_ptr : '0;
`else
                rd_ptr <= '0;
`endif
                remaining <= count;
            end else if (issue) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end

            in_flight <= issue;
            if (in_flight) begin
                obuf_wr <= ~obuf_wr;
            end
            if (pop) begin
                obuf_rd <= ~obuf_rd;
            end
            obuf_occ <= obuf_occ + {1'b0, in_flight} - {1'b0, pop};
        end
    end

    // NOTE: buffer storage is not reset; occupancy and the out_data gating
    // make stale contents invisible, so only control state needs reset.
    always_ff @(posedge clk) begin
        if (in_flight) begin
            obuf[obuf_wr] <= ram_q1;
        end
    end

endmodule

// File: tb/tb_trace_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trace_buffer_ctrl
//
// Directed bench for trace_buffer_ctrl with AddrWidth=4 (16-word buffer).
// A behavioural dual-port RAM model sits on the RAM ports. Expected values are
// hand-derived; results depend on whether TRACE_WRAP_EN is defined.
// -----------------------------------------------------------------------------
module tb_trace_buffer_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          stop;
    logic          dump;
    logic          ev_valid;
    logic [DW-1:0] ev_data;
    logic [AW-1:0] ram_addr0;
    logic [DW-1:0] ram_data0;
    logic          ram_ce0;
    logic          ram_we0;
    logic [AW-1:0] ram_addr1;
    logic          ram_ce1;
    logic          ram_we1;
    logic [DW-1:0] ram_q1;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic [AW:0]   count;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;

    int ready_pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

    always #5 clk = ~clk;

    trace_buffer_ctrl #(
        .DataWidth(DW),
        .AddrWidth(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .stop      (stop),
        .dump      (dump),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .ram_addr0 (ram_addr0),
        .ram_data0 (ram_data0),
        .ram_ce0   (ram_ce0),
        .ram_we0   (ram_we0),
        .ram_addr1 (ram_addr1),
        .ram_ce1   (ram_ce1),
        .ram_we1   (ram_we1),
        .ram_q1    (ram_q1),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .count     (count),
        .overrun   (overrun)
    );

    // Dual-port BRAM model: synchronous write on port 0, one-cycle read on port 1.
    logic [DW-1:0] mem [N];
    always @(posedge clk) begin
        if (ram_ce0 && ram_we0) mem[ram_addr0] <= ram_data0;
        if (ram_ce1) ram_q1 <= mem[ram_addr1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ports 0 and 1 must never be enabled together (capture and dump exclusive).
    always @(negedge clk) begin
        if (!rst) check("port_excl", {63'd0, ram_ce0 & ram_ce1}, 64'd0);
    end

    // Arm, capture n words base+i, then stop (optionally in the last event cycle).
    task automatic capture(input int n, input logic [DW-1:0] base, input bit stop_with_last);
        int exp_cnt;
        bit exp_we;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_busy", busy, 1);
        check("arm_count", count, 0);
        check("arm_overrun", overrun, 0);
        for (int i = 0; i < n; i++) begin
            ev_valid = 1'b1;
            ev_data  = base + DW'(i);
            stop     = stop_with_last && (i == n - 1);
            tick();
            exp_cnt = (i + 1 > N) ? N : i + 1;
`ifdef TRACE_WRAP_EN
            exp_we = 1'b1;
`else
            exp_we = (i < N);
`endif
            check("wr_count", count, exp_cnt);
            check("wr_strobe", {ram_ce0, ram_we0}, {exp_we, exp_we});
            if (exp_we) begin
                check("wr_addr", ram_addr0, i % N);
                check("wr_data", ram_data0, base + DW'(i));
            end
        end
        ev_valid = 1'b0;
        if (!stop_with_last) begin
            stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        check("stop_idle", busy, 0);
    endtask

    // Pulse dump and drain; expected words are exp_base+k for k < n_exp.
    // stop_after > 0 leaves the loop right after that many handshakes.
    task automatic run_dump(input string tag, input int n_exp, input logic [DW-1:0] exp_base,
                            input bit pattern, input int stop_after);
        logic [DW-1:0] got_q[$];
        logic [DW-1:0] prev_data;
        bit stall_prev;
        int first_valid;
        int first_hs;
        int last_hs;
        int busy_cycles;
        got_q.delete();
        stall_prev  = 1'b0;
        prev_data   = '0;
        first_valid = -1;
        first_hs    = -1;
        last_hs     = -1;
        busy_cycles = 0;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) break;
            busy_cycles++;
            out_ready = pattern ? (ready_pat[c % 8] != 0) : 1'b1;
            #1;
            if (c == 0) check({tag, "_first_rd"}, ram_ce1, (n_exp > 0));
            if (stall_prev) check({tag, "_stall_hold"}, {out_valid, out_data}, {1'b1, prev_data});
            if (out_valid && first_valid < 0) first_valid = c;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            tick();
            if (stop_after > 0 && got_q.size() == stop_after) break;
        end
        out_ready = 1'b0;
        if (stop_after == 0) begin
            check({tag, "_exit_busy"}, busy, 0);
            check({tag, "_exit_valid"}, out_valid, 0);
        end
        check({tag, "_len"}, got_q.size(), n_exp);
        for (int k = 0; k < got_q.size() && k < n_exp; k++) begin
            check({tag, "_word"}, got_q[k], exp_base + DW'(k));
        end
        if (n_exp > 0 && !pattern && stop_after == 0) begin
            check({tag, "_latency"}, first_valid, 2);
            check({tag, "_throughput"}, last_hs - first_hs, n_exp - 1);
        end
        if (n_exp == 0) begin
            check({tag, "_busy_cycles"}, busy_cycles, 1);
            check({tag, "_no_valid"}, first_valid, -1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        arm       = 1'b0;
        stop      = 1'b0;
        dump      = 1'b0;
        ev_valid  = 1'b0;
        ev_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_ram0", {ram_addr0, ram_data0, ram_ce0, ram_we0}, 0);
        check("rst_ram1", {ram_addr1, ram_ce1, ram_we1}, 0);
        check("rst_out", {out_valid, out_data, busy, count, overrun}, 0);
        rst = 1'b0;
        tick();

        // Basic capture of 5 words and full-speed dump.
        capture(5, 32'hA0, 1'b0);
        check("t1_count", count, 5);
        check("t1_overrun", overrun, 0);
        run_dump("t1", 5, 32'hA0, 1'b0, 0);

        // 20 events into a 16-word buffer.
        capture(20, 32'd0, 1'b0);
        check("t2_count", count, 16);
        check("t2_overrun", overrun, 1);
`ifdef TRACE_WRAP_EN
        run_dump("t2", 16, 32'd4, 1'b0, 0);
        run_dump("t2_again", 16, 32'd4, 1'b1, 0);
`else
        run_dump("t2", 16, 32'd0, 1'b0, 0);
        run_dump("t2_again", 16, 32'd0, 1'b1, 0);
`endif

        // 8 words drained under a stalling ready pattern.
        capture(8, 32'h100, 1'b0);
        run_dump("t3", 8, 32'h100, 1'b1, 0);

        // Reset after 3 of 8 words.
        run_dump("t4", 3, 32'h100, 1'b0, 3);
        rst = 1'b1;
        tick();
        check("t4_rst_ram0", {ram_addr0, ram_data0, ram_ce0, ram_we0}, 0);
        check("t4_rst_ram1", {ram_addr1, ram_ce1, ram_we1}, 0);
        check("t4_rst_out", {out_valid, out_data, busy, count, overrun}, 0);
        rst = 1'b0;
        tick();

        // Empty dump, then re-arm with 2 words.
        run_dump("t5_empty", 0, 32'd0, 1'b0, 0);
        capture(2, 32'h200, 1'b0);
        check("t5_count", count, 2);
        run_dump("t5", 2, 32'h200, 1'b0, 0);

        // Event coincident with stop is kept as the last word.
        capture(2, 32'h54, 1'b1);
        check("t6_count", count, 2);
        run_dump("t6", 2, 32'h54, 1'b0, 0);

        // arm and dump together in IDLE: arm wins.
        arm  = 1'b1;
        dump = 1'b1;
        tick();
        arm  = 1'b0;
        dump = 1'b0;
        check("t7_busy", busy, 1);
        check("t7_count", count, 0);
        ev_valid = 1'b1;
        ev_data  = 32'h77;
        tick();
        ev_valid = 1'b0;
        check("t7_capture_count", count, 1);
        check("t7_still_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t7_stop", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
